purifier_buffer: RTL and testbench

- Synchronous single-clock FIFO; 16-bit data words by default.
- Provides full, almost_full, empty and almost_empty status flags.
- Used as one 16-bit slice of a wide tagger-event buffer: several instances run in lockstep, with identical wr_en/rd_en, to form one wide word.
- The upstream writer uses almost_full for overflow detection; the reader uses almost_empty.

---
 rtl/purifier_buffer.sv | 85 ++++++++
 tb/tb_purifier_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/purifier_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : purifier_buffer
//  Purpose  : Single-clock FIFO slice with registered full/almost_full/
//             empty/almost_empty flags and registered (non-FWFT) read data.
//  Revision : 1.0 - initial release
// ============================================================================
module purifier_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = (ADDR_WIDTH)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance depends only on registered flags, so lockstep slices agree.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr];
      end
      count        <= count_nxt;
      // Flags track the post-edge count so they never lag the data state.
      full         <= (count_nxt == CNT_FULL);
      almost_full  <= (count_nxt >= CNT_AFULL);
      empty        <= (count_nxt == '0);
      almost_empty <= (count_nxt <= CNT_ONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_purifier_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_purifier_buffer
//  Purpose  : Scoreboard bench for purifier_buffer with directed stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_purifier_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] dout;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic        almost_empty;

  purifier_buffer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .almost_empty(almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] mq[$];
  logic [15:0] sbq[$];
  int          m_cnt;
  logic [15:0] exp_dout;
  logic        mon_en;
  logic [15:0] wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own count.
  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    logic wa;
    logic ra;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    wa = w && (m_cnt != 512);
    ra = r && (m_cnt != 0);
    if (ra) sbq.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    m_cnt = m_cnt + int'(wa) - int'(ra);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, wdata);
      wdata = wdata + 16'd1;
    end
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 16'h0);
  endtask

  // Monitor: after every edge, pop any read issued and compare data and flags.
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (sbq.size() != 0) exp_dout = sbq.pop_front();
      check("dout", {16'h0, dout}, {16'h0, exp_dout});
      check("flags{full,afull,empty,aempty}",
            {28'h0, full, almost_full, empty, almost_empty},
            {28'h0, m_cnt == 512, m_cnt >= 511, m_cnt == 0, m_cnt <= 1});
    end
  end

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = 16'h0;
    mon_en   = 1'b0;
    exp_dout = 16'h0;
    m_cnt    = 0;
    wdata    = 16'h0;

    repeat (2) @(negedge clk);
    #1;
    check("por_dout", {16'h0, dout}, 32'h0);
    check("por_flags", {28'h0, full, almost_full, empty, almost_empty}, 32'h3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // Single word, then keep reading while empty
    cyc(1'b1, 1'b0, 16'hA5A5);
    pop_n(4);
    idle(2);

    // Asynchronous reset mid-cycle with words stored
    cyc(1'b1, 1'b0, 16'h1234);
    cyc(1'b1, 1'b0, 16'h5678);
    cyc(1'b0, 1'b1, 16'h0);
    @(negedge clk);
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dout", {16'h0, dout}, 32'h0);
    check("rst_empty", {31'h0, empty}, 32'h1);
    check("rst_aempty", {31'h0, almost_empty}, 32'h1);
    check("rst_full", {31'h0, full}, 32'h0);
    check("rst_afull", {31'h0, almost_full}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    sbq.delete();
    m_cnt    = 0;
    exp_dout = 16'h0;
    mon_en   = 1'b1;
    idle(3);

    // Fill to full, overflow write, drain in order
    wdata = 16'h0000;
    push_n(512);
    cyc(1'b1, 1'b0, 16'hFFFF);
    pop_n(512);
    idle(2);

    // Pointer wrap-around
    wdata = 16'h1000;
    push_n(300);
    pop_n(300);
    push_n(400);
    pop_n(400);
    idle(2);

    // Concurrent read/write at count 5, then both on empty
    wdata = 16'h3000;
    push_n(5);
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b1, wdata);
      wdata = wdata + 16'd1;
    end
    pop_n(5);
    cyc(1'b1, 1'b1, 16'hC0DE);
    pop_n(2);
    idle(2);

    // Full with simultaneous read: read taken, write dropped
    wdata = 16'h7000;
    push_n(512);
    cyc(1'b1, 1'b1, 16'hBEEF);
    idle(1);
    pop_n(512);
    idle(2);

    mon_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
